multicycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle CPU datapath. Each instruction is sequenced through fetch, decode, execute, memory and write-back. The block drives the PC update enable and select, the IR/register-file/memory strobes and the ALU operand/op selects. It stalls on a memory ready handshake, flags illegal opcodes, and counts retired instructions.

---
 rtl/multicycle_ctrl_pkg.sv | 59 +++++
 rtl/multicycle_ctrl.sv | 142 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: state, opcode and control-field encodings shared by the
// multi-cycle controller, its datapath and its testbench.
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WB,
      S_MEM_WR,
      S_EXEC_R,
      S_R_WB,
      S_BRANCH,
      S_JUMP,
      S_EXEC_I,
      S_I_WB,
      S_HALT
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic [1:0] PC_SRC_ALU = 2'b00;
   localparam logic [1:0] PC_SRC_OUT = 2'b01;
   localparam logic [1:0] PC_SRC_JMP = 2'b10;

   localparam logic [1:0] ALU_B_REG  = 2'b00;
   localparam logic [1:0] ALU_B_FOUR = 2'b01;
   localparam logic [1:0] ALU_B_IMM  = 2'b10;
   localparam logic [1:0] ALU_B_IMM4 = 2'b11;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   typedef struct packed {
      logic       pc_en;
      logic [1:0] pc_src;
      logic       ir_write;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       illegal;
      logic       retire;
   } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/memory/write-back sequencer for the
// multi-cycle CPU, with memory-ready stalls and a retired-instruction counter.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic [1:0]       pc_src,
   output logic             ir_write,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             illegal,
   output logic             retire,
   output logic [CNT_W-1:0] instr_count
);

   state_t state, nx;
   ctrl_t  c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_FETCH;
         instr_count <= '0;
      end else begin
         state <= nx;
         if (c.retire) instr_count <= instr_count + CNT_W'(1);
      end
   end

   always_comb begin
      c  = '0;
      nx = state;
      case (state)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = ALU_B_FOUR;
            c.alu_op    = ALU_OP_ADD;
            c.ir_write  = mem_ready;
            c.pc_en     = mem_ready;
            c.pc_src    = PC_SRC_ALU;
            nx          = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            c.alu_src_b = ALU_B_IMM4;
            c.alu_op    = ALU_OP_ADD;
            case (opcode)
               OP_LW, OP_SW: nx = S_MEM_ADDR;
               OP_R:         nx = S_EXEC_R;
               OP_BEQ:       nx = S_BRANCH;
               OP_J:         nx = S_JUMP;
               OP_ADDI:      nx = S_EXEC_I;
               OP_HALT:      nx = S_HALT;
               default: begin
                  c.illegal = 1'b1;
                  nx        = S_FETCH;
               end
            endcase
         end
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = ALU_B_IMM;
            c.alu_op    = ALU_OP_ADD;
            nx          = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
            nx         = mem_ready ? S_MEM_WB : S_MEM_RD;
         end
         S_MEM_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            c.retire     = 1'b1;
            nx           = S_FETCH;
         end
         S_MEM_WR: begin
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
            c.retire    = mem_ready;
            nx          = mem_ready ? S_FETCH : S_MEM_WR;
         end
         S_EXEC_R: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = ALU_B_REG;
            c.alu_op    = ALU_OP_FUNCT;
            nx          = S_R_WB;
         end
         S_R_WB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
            c.retire    = 1'b1;
            nx          = S_FETCH;
         end
         S_BRANCH: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = ALU_B_REG;
            c.alu_op    = ALU_OP_SUB;
            c.pc_src    = PC_SRC_OUT;
            c.pc_en     = zero;
            c.retire    = 1'b1;
            nx          = S_FETCH;
         end
         S_JUMP: begin
            c.pc_src = PC_SRC_JMP;
            c.pc_en  = 1'b1;
            c.retire = 1'b1;
            nx       = S_FETCH;
         end
         S_EXEC_I: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = ALU_B_IMM;
            c.alu_op    = ALU_OP_ADD;
            nx          = S_I_WB;
         end
         S_I_WB: begin
            c.reg_write = 1'b1;
            c.retire    = 1'b1;
            nx          = S_FETCH;
         end
         S_HALT:  nx = S_HALT;
         default: nx = S_FETCH;
      endcase
   end

   // Reset silences every strobe even though the state register already sits in FETCH.
   assign {pc_en, pc_src, ir_write, i_or_d, mem_read, mem_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, illegal, retire} = rst_n ? c : '0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomized instruction streams checked cycle by
// cycle against a per-instruction expected control trace.
module tb_multicycle_ctrl;
   import multicycle_ctrl_pkg::*;

   localparam int CNT_W = 4;

   typedef struct packed {
      logic       pc_en;
      logic [1:0] pc_src;
      logic       ir_write;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       illegal;
      logic       retire;
   } exp_t;

   typedef struct {
      logic mr;
      logic z;
      exp_t exp;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [5:0] opcode = '0;
   logic zero = 1'b0;
   logic mem_ready = 1'b0;
   logic pc_en, ir_write, i_or_d, mem_read, mem_write, reg_dst, mem_to_reg, reg_write;
   logic alu_src_a, illegal, retire;
   logic [1:0] pc_src, alu_src_b, alu_op;
   logic [CNT_W-1:0] instr_count;
   exp_t obs;
   ent_t q[$];
   logic [CNT_W-1:0] cnt_m = '0;
   int passed = 0;
   int total = 0;

   multicycle_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_en(pc_en), .pc_src(pc_src), .ir_write(ir_write), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal), .retire(retire),
      .instr_count(instr_count)
   );

   assign obs = {pc_en, pc_src, ir_write, i_or_d, mem_read, mem_write, reg_dst, mem_to_reg,
                 reg_write, alu_src_a, alu_src_b, alu_op, illegal, retire};

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   task automatic chk_vec(input string tag, input int cyc, input exp_t act, input exp_t exp);
      total++;
      assert (act === exp) passed++;
      else $error("FAIL %s cycle %0d: controls %h expected %h", tag, cyc, act, exp);
   endtask

   task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
      total++;
      assert (act === exp) passed++;
      else $error("FAIL %s instr_count: got %0d expected %0d", tag, act, exp);
   endtask

   task automatic push(input logic mr, input logic z, input exp_t e);
      q.push_back('{mr, z, e});
   endtask

   // Expected trace for one instruction: one entry per clock with the inputs to drive.
   task automatic build(input logic [5:0] op, input int fw, input int mw, input logic z);
      exp_t e;
      logic legal;
      legal = op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_HALT};
      q.delete();
      e = '0; e.mem_read = 1'b1; e.alu_src_b = ALU_B_FOUR;
      repeat (fw) push(1'b0, rb(), e);
      e.ir_write = 1'b1; e.pc_en = 1'b1; e.pc_src = PC_SRC_ALU;
      push(1'b1, rb(), e);
      e = '0; e.alu_src_b = ALU_B_IMM4; e.illegal = !legal;
      push(rb(), rb(), e);
      if (op == OP_LW || op == OP_SW) begin
         e = '0; e.alu_src_a = 1'b1; e.alu_src_b = ALU_B_IMM;
         push(rb(), rb(), e);
         e = '0; e.i_or_d = 1'b1;
         if (op == OP_LW) begin
            e.mem_read = 1'b1;
            repeat (mw) push(1'b0, rb(), e);
            push(1'b1, rb(), e);
            e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.retire = 1'b1;
            push(rb(), rb(), e);
         end else begin
            e.mem_write = 1'b1;
            repeat (mw) push(1'b0, rb(), e);
            e.retire = 1'b1;
            push(1'b1, rb(), e);
         end
      end else if (op == OP_R) begin
         e = '0; e.alu_src_a = 1'b1; e.alu_src_b = ALU_B_REG; e.alu_op = ALU_OP_FUNCT;
         push(rb(), rb(), e);
         e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1; e.retire = 1'b1;
         push(rb(), rb(), e);
      end else if (op == OP_BEQ) begin
         e = '0; e.alu_src_a = 1'b1; e.alu_op = ALU_OP_SUB; e.pc_src = PC_SRC_OUT;
         e.pc_en = z; e.retire = 1'b1;
         push(rb(), z, e);
      end else if (op == OP_J) begin
         e = '0; e.pc_src = PC_SRC_JMP; e.pc_en = 1'b1; e.retire = 1'b1;
         push(rb(), rb(), e);
      end else if (op == OP_ADDI) begin
         e = '0; e.alu_src_a = 1'b1; e.alu_src_b = ALU_B_IMM;
         push(rb(), rb(), e);
         e = '0; e.reg_write = 1'b1; e.retire = 1'b1;
         push(rb(), rb(), e);
      end else if (op == OP_HALT) begin
         repeat (20) push(rb(), rb(), '0);
      end
   endtask

   task automatic run_q(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         mem_ready = q[i].mr;
         zero = q[i].z;
         #1 chk_vec(tag, i, obs, q[i].exp);
      end
   endtask

   task automatic run(input logic [5:0] op, input int fw, input int mw, input logic z, input string tag);
      build(op, fw, mw, z);
      opcode = op;
      run_q(tag, q.size());
      if (q[q.size()-1].exp.retire) cnt_m = cnt_m + CNT_W'(1);
      @(posedge clk);
      #1 chk_cnt(tag, instr_count, cnt_m);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      mem_ready = 1'b1;
      #3 chk_vec(tag, 0, obs, '0);
      chk_cnt(tag, instr_count, '0);
      cnt_m = '0;
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      logic [5:0] ops [10];
      ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, 6'h3E, 6'h01, 6'h0F, 6'h2A};
      do_reset("reset");
      run(OP_R, 0, 0, 1'b0, "r_type");
      run(OP_LW, 3, 2, 1'b0, "lw_stall");
      run(OP_BEQ, 0, 0, 1'b1, "beq_taken");
      run(OP_BEQ, 0, 0, 1'b0, "beq_not_taken");
      run(6'h3E, 0, 0, 1'b0, "illegal");
      run(OP_SW, 1, 3, 1'b0, "sw_stall");
      run(OP_ADDI, 0, 0, 1'b0, "addi");
      run(OP_J, 2, 0, 1'b0, "jump");
      for (int k = 0; k < 40; k++)
         run(ops[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 3), rb(), "random");
      run(OP_HALT, 0, 0, 1'b0, "halt");
      do_reset("halt_reset");
      for (int k = 0; k < 16; k++) run(OP_J, 0, 0, 1'b0, "wrap");
      run(OP_R, 0, 0, 1'b0, "pre_abort");
      build(OP_SW, 0, 5, 1'b0);
      opcode = OP_SW;
      run_q("sw_abort", 4);
      do_reset("abort_reset");
      run(OP_R, 0, 0, 1'b0, "post_abort");
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
